led_wishbone_slave: RTL and testbench

Memory-mapped LED output register on the SoC's single-master Wishbone-style data bus. The top-level address decoder asserts STB_I when the CPU accesses address 0xFFFF0000. A write latches the low data bits into a register that drives the board LEDs directly. The register can be read back so firmware can do read-modify-write on individual LEDs.

---
 rtl/led_wishbone_slave_pkg.sv | 5 +
 rtl/led_wishbone_slave_if.sv | 22 ++
 rtl/led_wishbone_slave.sv | 38 +++
 tb/tb_led_wishbone_slave.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/led_wishbone_slave_pkg.sv
// Shared SoC bus constants for the LED output register.
package led_wishbone_slave_pkg;
  localparam logic [31:0] LED_BASE_ADDR = 32'hFFFF_0000;
  localparam int          BUS_DATA_W    = 32;
endpackage

// File: rtl/led_wishbone_slave_if.sv
// Wishbone-style single-master data bus seen by one memory-mapped slave.
interface led_wishbone_slave_if #(
  parameter int WIDTH = 16
);
  import led_wishbone_slave_pkg::*;

  logic                  STB_I;
  logic                  WE_I;
  logic [WIDTH-1:0]      DAT_I;
  logic [BUS_DATA_W-1:0] DAT_O;
  logic                  ACK_O;

  modport master (
    output STB_I, WE_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  STB_I, WE_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/led_wishbone_slave.sv
// LED output register: writes land one clock later on O_led, reads are combinational.
// Zero wait states: ACK_O mirrors STB_I, so the master is never stalled.
module led_wishbone_slave
  import led_wishbone_slave_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               ACTIVE_LOW  = 1'b0
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  led_wishbone_slave_if.slave bus,
  output logic [WIDTH-1:0]   O_led
);

  logic [WIDTH-1:0]      led_q;
  logic [BUS_DATA_W-1:0] rd_dat;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      led_q <= RESET_VALUE;
    end else if (bus.STB_I && bus.WE_I) begin
      led_q <= bus.DAT_I;
    end
  end

  // Zero-extend through a variable so WIDTH=32 needs no zero-width replication.
  always_comb begin
    rd_dat             = '0;
    rd_dat[WIDTH-1:0]  = led_q;
  end

  // Idle slaves drive zero so the decoder can OR all read buses together.
  assign bus.DAT_O = (bus.STB_I && !bus.WE_I) ? rd_dat : '0;
  assign bus.ACK_O = bus.STB_I;
  assign O_led     = ACTIVE_LOW ? ~led_q : led_q;

endmodule

// File: tb/tb_led_wishbone_slave.sv
// Two LED slaves (active-high / active-low with non-zero reset) driven in lockstep,
// checked every cycle against a reference register model via a scoreboard queue.
module tb_led_wishbone_slave;
  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [15:0] dat;
  logic [15:0] led0;
  logic [15:0] led1;

  typedef struct {
    logic        ack;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [15:0] led0;
    logic [15:0] led1;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: what each LED register should hold right now.
  logic [15:0] m0, m1;
  logic        rst_r, stb_r, we_r;
  logic [15:0] dat_r;

  led_wishbone_slave_if #(.WIDTH(16)) bus0 ();
  led_wishbone_slave_if #(.WIDTH(16)) bus1 ();

  assign bus0.STB_I = stb;
  assign bus0.WE_I  = we;
  assign bus0.DAT_I = dat;
  assign bus1.STB_I = stb;
  assign bus1.WE_I  = we;
  assign bus1.DAT_I = dat;

  led_wishbone_slave #(.WIDTH(16), .RESET_VALUE(16'h0000), .ACTIVE_LOW(1'b0)) dut0 (
    .CLK_I(clk), .RST_I(rst), .bus(bus0), .O_led(led0)
  );

  led_wishbone_slave #(.WIDTH(16), .RESET_VALUE(16'h00FF), .ACTIVE_LOW(1'b1)) dut1 (
    .CLK_I(clk), .RST_I(rst), .bus(bus1), .O_led(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One bus cycle: retire the previous cycle's write into the model at the edge,
  // then drive new inputs mid-cycle and queue what the outputs must show.
  task automatic cyc(input bit r, input bit s, input bit w, input logic [15:0] d);
    exp_t e;
    @(posedge clk);
    if (!rst_r && stb_r && we_r) begin
      m0 = dat_r;
      m1 = dat_r;
    end
    #1;
    rst = r; stb = s; we = w; dat = d;
    rst_r = r; stb_r = s; we_r = w; dat_r = d;
    if (r) begin
      m0 = 16'h0000;
      m1 = 16'h00FF;
    end
    e.ack  = s;
    e.rd0  = (s && !w) ? 32'(m0) : 32'h0;
    e.rd1  = (s && !w) ? 32'(m1) : 32'h0;
    e.led0 = m0;
    e.led1 = 16'hFFFF - m1;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack0", 32'(bus0.ACK_O), 32'(e.ack));
        check("ack1", 32'(bus1.ACK_O), 32'(e.ack));
        check("dat_o0", bus0.DAT_O, e.rd0);
        check("dat_o1", bus1.DAT_O, e.rd1);
        check("led0", 32'(led0), 32'(e.led0));
        check("led1", 32'(led1), 32'(e.led1));
      end
    end
  end

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; dat = 16'h0;
    rst_r = 1'b1; stb_r = 1'b0; we_r = 1'b0; dat_r = 16'h0;
    m0 = 16'h0000; m1 = 16'h00FF;

    // Reset, then a clean write that later idle data must not disturb.
    cyc(1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 16'h0000);
    cyc(0, 1, 1, 16'hA5C3);
    cyc(0, 0, 0, 16'hFFFF);
    cyc(0, 0, 1, 16'hFFFF);
    // Reset asserted mid-cycle must clear O_led before the next edge.
    cyc(1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0000);
    // Read-back.
    cyc(0, 1, 1, 16'h1234);
    cyc(0, 1, 0, 16'hDEAD);
    cyc(0, 0, 0, 16'h0000);
    // Back-to-back writes, then read right after a write.
    cyc(0, 1, 1, 16'h0001);
    cyc(0, 1, 1, 16'h8000);
    cyc(0, 1, 1, 16'hFFFF);
    cyc(0, 1, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0000);
    // Reset across a write edge discards it; next write after release lands.
    cyc(1, 1, 1, 16'h5555);
    cyc(0, 1, 1, 16'h5555);
    cyc(0, 0, 0, 16'h0000);
    // Active-low instance readback.
    cyc(0, 1, 1, 16'h0F0F);
    cyc(0, 1, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, 16'($urandom));
    end
    cyc(0, 0, 0, 16'h0000);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
